uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_if.sv | 24 ++
 rtl/uart_sync2.sv | 22 ++
 rtl/uart_rx.sv | 110 +++++++++++
 tb/tb_uart_rx.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: rx FSM state encoding and default frame geometry.
// Also meant to be imported by the matching transmitter.
package uart_pkg;

    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Consumer-side bus of the UART receiver: received byte, valid/read handshake, status flags.
// master = receiver, slave = consumer.
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS
);
    logic [DATA_BITS-1:0] RxData;
    logic                 RxValid;
    logic                 RxRead;
    logic                 FrameErr;
    logic                 Overrun;
    logic                 Busy;

    modport master (
        output RxData, RxValid, FrameErr, Overrun, Busy,
        input  RxRead
    );

    modport slave (
        input  RxData, RxValid, FrameErr, Overrun, Busy,
        output RxRead
    );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous bit.
// Latency: 2 Clk. No backpressure.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic Clk,
    input  logic Rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start validation at mid-bit, LSB-first data, stop check.
// Latency: byte valid at stop-bit centre. No backpressure; unread bytes are overwritten and flagged.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic      Clk,
    input  logic      Rst,
    input  logic      Tick,
    input  logic      Rx,
    uart_rx_if.master bus
);
    localparam int SCW = $clog2(OVERSAMPLE);
    localparam int BCW = $clog2(DATA_BITS);
    localparam logic [SCW-1:0] SMP_HALF = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] SMP_FULL = SCW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);

    rx_state_t            state, state_nxt;
    logic                 rx_s;
    logic [SCW-1:0]       smp_cnt;
    logic [BCW-1:0]       bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 overrun;
    logic                 armed;
    logic                 busy;
    logic                 data_shift;
    logic                 good_done;
    logic                 stop_bad;

    wire mid_tick = Tick && (smp_cnt == SMP_HALF);
    wire ctr_tick = Tick && (smp_cnt == SMP_FULL);

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .Clk (Clk),
        .Rst (Rst),
        .d   (Rx),
        .q   (rx_s)
    );

    always_ff @(posedge Clk) begin
        if (Rst) state <= RX_IDLE;
        else     state <= state_nxt;
    end

    // armed gates start detection so a line stuck low after a bad stop or reset is not taken as a start
    always_comb begin
        state_nxt = state;
        case (state)
            RX_IDLE:  if (armed && !rx_s) state_nxt = RX_START;
            RX_START: if (mid_tick)       state_nxt = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (ctr_tick && bit_cnt == BIT_LAST) state_nxt = RX_STOP;
            RX_STOP:  if (ctr_tick)       state_nxt = RX_IDLE;
            default:                      state_nxt = RX_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != RX_IDLE);
        data_shift = (state == RX_DATA) && ctr_tick;
        good_done  = (state == RX_STOP) && ctr_tick && rx_s;
        stop_bad   = (state == RX_STOP) && ctr_tick && !rx_s;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            smp_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            armed     <= 1'b0;
        end else begin
            if (state_nxt != state)  smp_cnt <= '0;
            else if (busy && Tick)   smp_cnt <= smp_cnt + 1'b1;

            if (state != RX_DATA)    bit_cnt <= '0;
            else if (data_shift)     bit_cnt <= bit_cnt + 1'b1;

            if (data_shift) shreg <= {rx_s, shreg[DATA_BITS-1:1]};

            if (stop_bad)   armed <= 1'b0;
            else if (rx_s)  armed <= 1'b1;

            frame_err <= stop_bad;

            if (good_done) rx_data <= shreg;

            if (good_done)        rx_valid <= 1'b1;
            else if (bus.RxRead)  rx_valid <= 1'b0;

            // a read in the completion cycle consumes the old byte, so no overrun
            if (good_done && rx_valid && !bus.RxRead) overrun <= 1'b1;
            else if (bus.RxRead)                      overrun <= 1'b0;
        end
    end

    assign bus.RxData   = rx_data;
    assign bus.RxValid  = rx_valid;
    assign bus.FrameErr = frame_err;
    assign bus.Overrun  = overrun;
    assign bus.Busy     = busy;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: Tick every 4 Clk, 16x oversampling, 64 Clk per bit.
module tb_uart_rx;
    localparam int BIT_CLKS = 64;

    logic Clk  = 1'b0;
    logic Rst  = 1'b1;
    logic Tick = 1'b0;
    logic Rx   = 1'b1;
    int   div  = 0;
    int   tests = 0;
    int   fails = 0;
    int   fe_cnt = 0;

    uart_rx_if #(.DATA_BITS(8)) bus ();

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .Clk  (Clk),
        .Rst  (Rst),
        .Tick (Tick),
        .Rx   (Rx),
        .bus  (bus)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        div  = (div + 1) % 4;
        Tick = (div == 0);
    end

    always @(negedge Clk) begin
        if (bus.FrameErr === 1'b1) fe_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_clks);
        Rx = 1'b0;
        repeat (BIT_CLKS) @(negedge Clk);
        for (int i = 0; i < 8; i++) begin
            Rx = d[i];
            repeat (BIT_CLKS) @(negedge Clk);
        end
        Rx = stop;
        repeat (stop_clks) @(negedge Clk);
        Rx = 1'b1;
        repeat (BIT_CLKS) @(negedge Clk);
    endtask

    task automatic read_pulse();
        bus.RxRead = 1'b1;
        @(negedge Clk);
        bus.RxRead = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_reset();
        tests++; if (bus.RxValid  !== 1'b0)  begin fails++; $display("FAIL reset_valid: got %b want 0", bus.RxValid); end
        tests++; if (bus.RxData   !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", bus.RxData); end
        tests++; if (bus.FrameErr !== 1'b0)  begin fails++; $display("FAIL reset_ferr: got %b want 0", bus.FrameErr); end
        tests++; if (bus.Overrun  !== 1'b0)  begin fails++; $display("FAIL reset_ovr: got %b want 0", bus.Overrun); end
        tests++; if (bus.Busy     !== 1'b0)  begin fails++; $display("FAIL reset_busy: got %b want 0", bus.Busy); end
    endtask

    task automatic test_good_frame();
        fe_cnt = 0;
        send_frame(8'h55, 1'b1, BIT_CLKS);
        tests++; if (bus.RxData  !== 8'h55) begin fails++; $display("FAIL good_data: got %h want 55", bus.RxData); end
        tests++; if (bus.RxValid !== 1'b1)  begin fails++; $display("FAIL good_valid: got %b want 1", bus.RxValid); end
        tests++; if (fe_cnt      !== 0)     begin fails++; $display("FAIL good_ferr: got %0d pulses want 0", fe_cnt); end
        tests++; if (bus.Overrun !== 1'b0)  begin fails++; $display("FAIL good_ovr: got %b want 0", bus.Overrun); end
        read_pulse();
        tests++; if (bus.RxValid !== 1'b0)  begin fails++; $display("FAIL good_read: got %b want 0", bus.RxValid); end
    endtask

    task automatic test_glitch();
        fe_cnt = 0;
        Rx = 1'b0;
        repeat (16) @(negedge Clk);
        tests++; if (bus.Busy !== 1'b1) begin fails++; $display("FAIL glitch_detect: busy got %b want 1", bus.Busy); end
        Rx = 1'b1;
        repeat (100) @(negedge Clk);
        tests++; if (bus.Busy    !== 1'b0) begin fails++; $display("FAIL glitch_idle: busy got %b want 0", bus.Busy); end
        tests++; if (bus.RxValid !== 1'b0) begin fails++; $display("FAIL glitch_valid: got %b want 0", bus.RxValid); end
        tests++; if (fe_cnt      !== 0)    begin fails++; $display("FAIL glitch_ferr: got %0d pulses want 0", fe_cnt); end
    endtask

    task automatic test_frame_err();
        fe_cnt = 0;
        // stop held low past its centre: the low line must not be taken as a new start
        send_frame(8'hA3, 1'b0, 2 * BIT_CLKS);
        repeat (800) @(negedge Clk);
        tests++; if (fe_cnt      !== 1)     begin fails++; $display("FAIL ferr_pulses: got %0d want 1", fe_cnt); end
        tests++; if (bus.RxValid !== 1'b0)  begin fails++; $display("FAIL ferr_valid: got %b want 0", bus.RxValid); end
        tests++; if (bus.RxData  !== 8'h55) begin fails++; $display("FAIL ferr_data: got %h want 55", bus.RxData); end
        tests++; if (bus.Busy    !== 1'b0)  begin fails++; $display("FAIL ferr_busy: got %b want 0", bus.Busy); end
    endtask

    task automatic test_back_to_back();
        send_frame(8'h12, 1'b1, BIT_CLKS);
        send_frame(8'h34, 1'b1, BIT_CLKS);
        tests++; if (bus.RxData  !== 8'h34) begin fails++; $display("FAIL b2b_data: got %h want 34", bus.RxData); end
        tests++; if (bus.RxValid !== 1'b1)  begin fails++; $display("FAIL b2b_valid: got %b want 1", bus.RxValid); end
        tests++; if (bus.Overrun !== 1'b1)  begin fails++; $display("FAIL b2b_ovr: got %b want 1", bus.Overrun); end
        read_pulse();
        tests++; if (bus.RxValid !== 1'b0)  begin fails++; $display("FAIL b2b_read_valid: got %b want 0", bus.RxValid); end
        tests++; if (bus.Overrun !== 1'b0)  begin fails++; $display("FAIL b2b_read_ovr: got %b want 0", bus.Overrun); end
    endtask

    task automatic test_read_on_completion();
        int n;
        int k;
        n = 0;
        k = 0;
        send_frame(8'h11, 1'b1, BIT_CLKS);
        tests++; if (bus.RxData !== 8'h11) begin fails++; $display("FAIL roc_first: got %h want 11", bus.RxData); end
        fork
            send_frame(8'h7E, 1'b1, BIT_CLKS);
            begin
                while (bus.Busy !== 1'b1 && k < 300) begin
                    @(negedge Clk);
                    k++;
                end
                tests++;
                if (k >= 300) begin
                    fails++;
                    $display("FAIL roc_start_timeout: busy got %b want 1 within 300 cycles", bus.Busy);
                end else begin
                    // stop-bit centre is the 152nd Tick after start detection (8 + 16*8 + 16)
                    while (n < 152) begin
                        #1;
                        if (Tick) n++;
                        if (n == 152) bus.RxRead = 1'b1;
                        @(negedge Clk);
                    end
                    bus.RxRead = 1'b0;
                end
            end
        join
        tests++; if (bus.RxValid !== 1'b1)  begin fails++; $display("FAIL roc_valid: got %b want 1", bus.RxValid); end
        tests++; if (bus.RxData  !== 8'h7E) begin fails++; $display("FAIL roc_data: got %h want 7e", bus.RxData); end
        tests++; if (bus.Overrun !== 1'b0)  begin fails++; $display("FAIL roc_ovr: got %b want 0", bus.Overrun); end
    endtask

    task automatic test_reset_mid_frame();
        fe_cnt = 0;
        fork
            send_frame(8'hFF, 1'b1, BIT_CLKS);
            begin
                repeat (BIT_CLKS * 4 + BIT_CLKS / 2) @(negedge Clk);
                Rst = 1'b1;
                @(negedge Clk);
                Rst = 1'b0;
                tests++; if (bus.RxValid !== 1'b0)  begin fails++; $display("FAIL rmf_valid: got %b want 0", bus.RxValid); end
                tests++; if (bus.Busy    !== 1'b0)  begin fails++; $display("FAIL rmf_busy: got %b want 0", bus.Busy); end
                tests++; if (bus.RxData  !== 8'h00) begin fails++; $display("FAIL rmf_data: got %h want 00", bus.RxData); end
            end
        join
        repeat (100) @(negedge Clk);
        tests++; if (bus.RxValid !== 1'b0) begin fails++; $display("FAIL rmf_discard: valid got %b want 0", bus.RxValid); end
        send_frame(8'h0F, 1'b1, BIT_CLKS);
        tests++; if (bus.RxData  !== 8'h0F) begin fails++; $display("FAIL rmf_new_data: got %h want 0f", bus.RxData); end
        tests++; if (bus.RxValid !== 1'b1)  begin fails++; $display("FAIL rmf_new_valid: got %b want 1", bus.RxValid); end
        tests++; if (fe_cnt      !== 0)     begin fails++; $display("FAIL rmf_ferr: got %0d pulses want 0", fe_cnt); end
        tests++; if (bus.Overrun !== 1'b0)  begin fails++; $display("FAIL rmf_ovr: got %b want 0", bus.Overrun); end
    endtask

    initial begin
        bus.RxRead = 1'b0;
        Rst = 1'b1;
        repeat (3) @(negedge Clk);
        test_reset();
        Rst = 1'b0;
        repeat (8) @(negedge Clk);
        test_good_frame();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_read_on_completion();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
